// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: chooses the next PC source, qualifies fetch packets
// toward decode, drops stale icache responses after a redirect, parks on a
// fetch exception and watches for icache responses that never arrive.
module if_fetch_ctrl #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            stall_i,
  input  logic            commit_redirect_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            exe_redirect_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            dec_redirect_i,
  input  logic [XLEN-1:0] dec_pc_i,
  input  logic            icache_valid_i,
  input  logic            fetch_ex_i,
  output logic [1:0]      next_pc_sel_o,
  output logic [XLEN-1:0] pc_jump_o,
  output logic            fetch_valid_o,
  output logic            timeout_o,
  output logic [1:0]      state_o
);

  localparam int unsigned WDOG_W = $clog2(MAX_WAIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(MAX_WAIT);

  localparam logic [1:0] SEL_PC   = 2'd0;
  localparam logic [1:0] SEL_PC_4 = 2'd1;
  localparam logic [1:0] SEL_JUMP = 2'd2;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EXC   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              ex_q, ex_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              redir;
  logic              resp;

  assign redir = commit_redirect_i | exe_redirect_i | dec_redirect_i;
  assign resp  = icache_valid_i | fetch_ex_i;

  // Redirect target: commit beats execute beats decode.
  always_comb begin
    pc_jump_o = '0;
    if (commit_redirect_i)   pc_jump_o = commit_pc_i;
    else if (exe_redirect_i) pc_jump_o = exe_pc_i;
    else if (dec_redirect_i) pc_jump_o = dec_pc_i;
  end

  // State, held-exception flag and watchdog registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_WAIT;
      ex_q    <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next state, PC select and fetch qualification.
  always_comb begin
    state_d       = state_q;
    ex_d          = ex_q;
    next_pc_sel_o = SEL_PC;
    fetch_valid_o = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (redir) begin
          next_pc_sel_o = SEL_JUMP;
          // Without a response this cycle, the old one is still in flight.
          if (!resp) state_d = ST_DRAIN;
        end else if (resp) begin
          fetch_valid_o = 1'b1;
          if (stall_i) begin
            ex_d    = fetch_ex_i;
            state_d = ST_HOLD;
          end else if (fetch_ex_i) begin
            state_d = ST_EXC;
          end else begin
            next_pc_sel_o = SEL_PC_4;
          end
        end
      end
      ST_HOLD: begin
        if (redir) begin
          next_pc_sel_o = SEL_JUMP;
          state_d       = ST_WAIT;
        end else begin
          fetch_valid_o = 1'b1;
          if (!stall_i) begin
            if (ex_q) begin
              state_d = ST_EXC;
            end else begin
              next_pc_sel_o = SEL_PC_4;
              state_d       = ST_WAIT;
            end
          end
        end
      end
      ST_DRAIN: begin
        // A new redirect still leaves exactly one stale response to drop.
        if (redir) begin
          next_pc_sel_o = SEL_JUMP;
        end else if (icache_valid_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_EXC: begin
        if (redir) begin
          next_pc_sel_o = SEL_JUMP;
          state_d       = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Watchdog on cycles spent waiting for an icache response.
  always_comb begin
    wdog_d = '0;
    if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !icache_valid_i &&
        !redir && (state_d == state_q) && (wdog_q != WDOG_MAX)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  assign timeout_o = (wdog_q == WDOG_MAX);
  assign state_o   = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed vector table, reset-in-drain
// sequence, then randomized traffic against a behavioural model.
module tb_if_fetch_ctrl;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned MAX_WAIT = 4;

  localparam logic [1:0] P  = 2'd0;
  localparam logic [1:0] P4 = 2'd1;
  localparam logic [1:0] J  = 2'd2;

  localparam logic [63:0] CPC = 64'h200;
  localparam logic [63:0] EPC = 64'h1000;
  localparam logic [63:0] DPC = 64'h2000;

  logic            clk;
  logic            rstn;
  logic            stall, cr, er, dr, iv, fex;
  logic [XLEN-1:0] cpc, epc, dpc;
  logic [1:0]      sel;
  logic [XLEN-1:0] jmp;
  logic            fv, to;
  logic [1:0]      st;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_ctrl #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .stall_i          (stall),
    .commit_redirect_i(cr),
    .commit_pc_i      (cpc),
    .exe_redirect_i   (er),
    .exe_pc_i         (epc),
    .dec_redirect_i   (dr),
    .dec_pc_i         (dpc),
    .icache_valid_i   (iv),
    .fetch_ex_i       (fex),
    .next_pc_sel_o    (sel),
    .pc_jump_o        (jmp),
    .fetch_valid_o    (fv),
    .timeout_o        (to),
    .state_o          (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, cr, er, dr, iv, fex;
    logic [1:0]  sel;
    logic [63:0] jmp;
    logic        fv, to;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic c, input logic e, input logic d,
                     input logic v, input logic x, input logic [1:0] es,
                     input logic [63:0] ej, input logic ef, input logic et,
                     input logic [1:0] est);
    vec_t r;
    r.stall = s; r.cr = c; r.er = e; r.dr = d; r.iv = v; r.fex = x;
    r.sel = es; r.jmp = ej; r.fv = ef; r.to = et; r.st = est;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] es, input logic [63:0] ej,
                            input logic ef, input logic et, input logic [1:0] est);
    check({tag, " sel"}, 64'(sel), 64'(es));
    check({tag, " jmp"}, jmp, ej);
    check({tag, " fv"}, 64'(fv), 64'(ef));
    check({tag, " to"}, 64'(to), 64'(et));
    check({tag, " st"}, 64'(st), 64'(est));
  endtask

  task automatic drive(input logic s, input logic c, input logic e, input logic d,
                       input logic v, input logic x);
    stall = s; cr = c; er = e; dr = d; iv = v; fex = x;
  endtask

  // Behavioural model: fetch is parked, draining a stale response,
  // holding a stalled packet, or plainly waiting.
  bit m_stale, m_hold, m_hold_ex, m_park;
  int m_idle;

  function automatic int m_mode();
    return m_park ? 3 : m_stale ? 2 : m_hold ? 1 : 0;
  endfunction

  task automatic m_reset();
    m_stale = 0; m_hold = 0; m_hold_ex = 0; m_park = 0; m_idle = 0;
  endtask

  task automatic m_eval(output logic [1:0] es, output logic [63:0] ej,
                        output logic ef, output logic et, output logic [1:0] est);
    bit redir, resp;
    redir = cr | er | dr;
    resp  = iv | fex;
    ej  = cr ? cpc : er ? epc : dr ? dpc : 64'h0;
    es  = P;
    ef  = 1'b0;
    et  = (m_idle == int'(MAX_WAIT));
    est = 2'(m_mode());
    if (redir) es = J;
    else if (m_park || m_stale) es = P;
    else if (m_hold) begin
      ef = 1'b1;
      es = (stall || m_hold_ex) ? P : P4;
    end else if (resp) begin
      ef = 1'b1;
      es = (stall || fex) ? P : P4;
    end
  endtask

  task automatic m_step();
    bit redir, resp, counting;
    int old_mode;
    redir    = cr | er | dr;
    resp     = iv | fex;
    old_mode = m_mode();
    counting = (old_mode == 0) || (old_mode == 2);
    if (redir) begin
      m_stale = m_stale ? 1'b1 : (!m_hold && !m_park && !resp);
      m_hold  = 0;
      m_park  = 0;
    end else if (m_park) begin
    end else if (m_stale) begin
      if (iv) m_stale = 0;
    end else if (m_hold) begin
      if (!stall) begin
        m_hold = 0;
        m_park = m_hold_ex;
      end
    end else if (resp) begin
      if (stall) begin
        m_hold = 1; m_hold_ex = fex;
      end else if (fex) begin
        m_park = 1;
      end
    end
    if (!counting || iv || redir || m_mode() != old_mode || m_idle == int'(MAX_WAIT))
      m_idle = 0;
    else
      m_idle++;
  endtask

  initial begin
    logic [1:0]  es, est;
    logic [63:0] ej;
    logic        ef, et;

    rstn = 1'b0;
    cpc = CPC; epc = EPC; dpc = DPC;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check_outs("in_reset", P, 64'h0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    //   stall cr er dr iv fex   sel jmp fv to st
    add(0,0,0,0,0,0, P,  0,     0,0,0);   // reset idle
    add(0,0,0,0,1,0, P4, 0,     1,0,0);   // streaming
    add(0,0,0,0,1,0, P4, 0,     1,0,0);
    add(0,0,0,0,1,0, P4, 0,     1,0,0);
    add(1,0,0,0,1,0, P,  0,     1,0,0);   // stall -> HOLD
    add(1,0,0,0,1,0, P,  0,     1,0,1);
    add(1,0,0,0,1,0, P,  0,     1,0,1);
    add(0,0,0,0,1,0, P4, 0,     1,0,1);   // release
    add(0,0,1,1,0,0, J,  EPC,   0,0,0);   // exe beats dec -> DRAIN
    add(0,0,0,0,0,0, P,  0,     0,0,2);
    add(0,0,0,0,1,0, P,  0,     0,0,2);   // stale response dropped
    add(0,0,0,0,1,0, P4, 0,     1,0,0);
    add(0,0,0,0,0,1, P,  0,     1,0,0);   // fetch exception -> EXC
    add(0,0,0,0,0,0, P,  0,     0,0,3);
    add(0,0,0,0,0,0, P,  0,     0,0,3);
    add(0,1,0,0,0,0, J,  CPC,   0,0,3);   // commit leaves EXC
    for (int k = 0; k < 2; k++) begin     // watchdog period 5
      for (int i = 0; i < 4; i++) add(0,0,0,0,0,0, P, 0, 0,0,0);
      add(0,0,0,0,0,0, P, 0, 0,1,0);
    end
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, P, 0, 0,0,0);
    add(0,0,0,0,1,0, P4, 0,     1,0,0);   // response clears count
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,0, P, 0, 0,0,0);
    add(0,0,0,0,0,0, P,  0,     0,1,0);
    add(0,1,1,1,1,0, J,  CPC,   0,0,0);   // commit wins, resp consumed
    add(0,0,0,0,1,0, P4, 0,     1,0,0);
    add(0,0,0,1,0,0, J,  DPC,   0,0,0);   // dec redirect -> DRAIN
    add(0,0,1,0,1,0, J,  EPC,   0,0,2);   // redir+valid in DRAIN stays
    add(0,0,0,0,1,0, P,  0,     0,0,2);
    add(1,0,0,0,1,1, P,  0,     1,0,0);   // stalled exception -> HOLD
    add(1,0,0,0,1,1, P,  0,     1,0,1);
    add(0,0,0,0,1,1, P,  0,     1,0,1);   // release -> EXC
    add(0,0,0,0,0,0, P,  0,     0,0,3);
    add(0,0,1,0,0,0, J,  EPC,   0,0,3);
    add(1,0,0,0,1,0, P,  0,     1,0,0);   // HOLD again
    add(1,0,0,1,0,0, J,  DPC,   0,0,1);   // redirect out of HOLD
    add(0,0,0,0,0,0, P,  0,     0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].cr, tbl[i].er, tbl[i].dr, tbl[i].iv, tbl[i].fex);
      @(negedge clk);
      check_outs($sformatf("row%0d", i), tbl[i].sel, tbl[i].jmp, tbl[i].fv, tbl[i].to, tbl[i].st);
      @(posedge clk); #1;
    end

    // Reset asserted while draining: immediate return, no stale drop kept.
    drive(0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("drain_entered st", 64'(st), 64'd2);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check_outs("reset_in_drain", P, 64'h0, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check_outs("after_reset_resp", P4, 64'h0, 1'b1, 1'b0, 2'd0);
    @(posedge clk); #1;

    // Randomized traffic against the model, from a fresh reset.
    drive(0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #2 rstn = 1'b1;
    m_reset();
    for (int n = 0; n < 1500; n++) begin
      stall = ($urandom_range(0, 9) < 3);
      cr    = ($urandom_range(0, 99) < 4);
      er    = ($urandom_range(0, 99) < 6);
      dr    = ($urandom_range(0, 99) < 8);
      iv    = ($urandom_range(0, 99) < 40);
      fex   = ($urandom_range(0, 99) < 4);
      cpc   = {$urandom, $urandom};
      epc   = {$urandom, $urandom};
      dpc   = {$urandom, $urandom};
      @(negedge clk);
      m_eval(es, ej, ef, et, est);
      check_outs($sformatf("rand%0d", n), es, ej, ef, et, est);
      m_step();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
